// File: rtl/mca_stream_ctrl_pkg.sv
// Shared types and helpers for the MCA stream controller.
// The optional overrun counter feature is selected with MCA_OVERRUN_CNT_EN.
package mca_stream_ctrl_pkg;

   typedef logic [15:0] ovr_cnt_t;

   localparam ovr_cnt_t OVR_CNT_MAX = 16'hFFFF;

   // Bit position of control bit n of the sample accepted i samples ago (i=0 newest).
   function automatic int hist_idx(input int i, input int n, input int nbits);
      return i * nbits + n;
   endfunction

   // Counter width able to hold the values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mca_stream_ctrl_history.sv
// s_history_shreg: K-bit control history, shifted by N on each accepted sample,
// with a saturating fill counter. Exposes the post-shift view used for snapshots.
module s_history_shreg
   import mca_stream_ctrl_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 256
)(
   input  logic         clk,
   input  logic         resetn,
   input  logic         shift_en,
   input  logic [N-1:0] din,
   output logic [K-1:0] hist_next,
   output logic         full_next
);

   localparam int DEPTH  = K / N;
   localparam int FILL_W = cnt_w(DEPTH);

   logic [K-1:0]      hist_d, hist_q;
   logic [K-1:0]      shifted_s;
   logic [FILL_W-1:0] fill_cnt_d, fill_cnt_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      for (genvar gn = 0; gn < N; gn++) begin : g_bit
         localparam int DST = hist_idx(gi, gn, N);
         if (gi == 0) begin : g_new
            assign shifted_s[DST] = din[gn];
         end else begin : g_old
            localparam int SRC = hist_idx(gi - 1, gn, N);
            assign shifted_s[DST] = hist_q[SRC];
         end
      end
   end

   // Next history and fill count; both stall while no sample is accepted.
   always_comb begin
      hist_d     = hist_q;
      fill_cnt_d = fill_cnt_q;
      if (shift_en) begin
         hist_d = shifted_s;
         if (fill_cnt_q != FILL_W'(DEPTH)) begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
         end else begin
            fill_cnt_d = fill_cnt_q;
         end
      end else begin
         hist_d     = hist_q;
         fill_cnt_d = fill_cnt_q;
      end
   end

   // History and fill state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hist_q     <= {K{1'b0}};
         fill_cnt_q <= {FILL_W{1'b0}};
      end else begin
         hist_q     <= hist_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   assign hist_next = hist_d;
   assign full_next = (fill_cnt_d == FILL_W'(DEPTH));

endmodule

// File: rtl/mca_stream_ctrl.sv
// mca_stream_ctrl: decimating front-end sequencer for the MCA stage.
// Define MCA_OVERRUN_CNT_EN to get a saturating count of dropped decimation points.
module mca_stream_ctrl
   import mca_stream_ctrl_pkg::*;
#(
   parameter int N                 = 8,
   parameter int K                 = 256,
   parameter int DOWNSAMPLE_RATE   = 32,
   parameter int MCA_LATENCY       = 34,
   parameter int WIDTH_COEFFICIENT = 32
)(
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [N-1:0]                 ctrl_in,
   input  logic                         ctrl_valid,
   output logic [K-1:0]                 S_matrix,
   output logic                         start,
   input  logic [WIDTH_COEFFICIENT-1:0] mca_sample,
   output logic [WIDTH_COEFFICIENT-1:0] sample,
   output logic                         sample_valid,
   output logic                         overrun,
   output logic [15:0]                  overrun_cnt
);

   localparam int DS_CNT_W  = cnt_w(DOWNSAMPLE_RATE);
   localparam int LAT_CNT_W = cnt_w(MCA_LATENCY);

   if ((K % N) != 0 || (K % 4) != 0) begin : g_chk_k
      $error("mca_stream_ctrl: K must be a multiple of N and of 4");
   end
   if (DOWNSAMPLE_RATE < 1 || MCA_LATENCY < 1) begin : g_chk_rate
      $error("mca_stream_ctrl: DOWNSAMPLE_RATE and MCA_LATENCY must be >= 1");
   end
   if (WIDTH_COEFFICIENT < 1 || WIDTH_COEFFICIENT > 32) begin : g_chk_width
      $error("mca_stream_ctrl: WIDTH_COEFFICIENT must be 1..32");
   end

   logic [K-1:0]                 hist_next_s;
   logic                         full_next_s;
   logic                         point_s;
   logic [DS_CNT_W-1:0]          ds_cnt_d, ds_cnt_q;
   logic [LAT_CNT_W-1:0]         busy_cnt_d, busy_cnt_q;
   logic [K-1:0]                 s_matrix_d, s_matrix_q;
   logic                         start_d, start_q;
   logic [WIDTH_COEFFICIENT-1:0] sample_d, sample_q;
   logic                         sample_valid_d, sample_valid_q;
   logic                         overrun_d, overrun_q;

   s_history_shreg #(
      .N(N),
      .K(K)
   ) u_hist (
      .clk       (clk),
      .resetn    (resetn),
      .shift_en  (ctrl_valid),
      .din       (ctrl_in),
      .hist_next (hist_next_s),
      .full_next (full_next_s)
   );

   // Decimation, issue/overrun decision, MCA busy countdown and result capture.
   always_comb begin
      point_s        = 1'b0;
      ds_cnt_d       = ds_cnt_q;
      busy_cnt_d     = busy_cnt_q;
      s_matrix_d     = s_matrix_q;
      start_d        = 1'b0;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      overrun_d      = 1'b0;

      // The accept that fills the history already counts toward the first point.
      if (ctrl_valid && full_next_s) begin
         if (ds_cnt_q == DS_CNT_W'(DOWNSAMPLE_RATE - 1)) begin
            point_s  = 1'b1;
            ds_cnt_d = {DS_CNT_W{1'b0}};
         end else begin
            point_s  = 1'b0;
            ds_cnt_d = ds_cnt_q + DS_CNT_W'(1);
         end
      end else begin
         point_s  = 1'b0;
         ds_cnt_d = ds_cnt_q;
      end

      if (busy_cnt_q != {LAT_CNT_W{1'b0}}) begin
         busy_cnt_d = busy_cnt_q - LAT_CNT_W'(1);
      end else begin
         busy_cnt_d = busy_cnt_q;
      end

      if (busy_cnt_q == LAT_CNT_W'(1)) begin
         sample_d       = mca_sample;
         sample_valid_d = 1'b1;
      end else begin
         sample_d       = sample_q;
         sample_valid_d = 1'b0;
      end

      // busy_cnt==1 means the MCA finishes on this edge, so a new issue is allowed.
      if (point_s) begin
         if (busy_cnt_q > LAT_CNT_W'(1)) begin
            overrun_d = 1'b1;
         end else begin
            s_matrix_d = hist_next_s;
            start_d    = 1'b1;
            busy_cnt_d = LAT_CNT_W'(MCA_LATENCY);
         end
      end else begin
         overrun_d = 1'b0;
         start_d   = 1'b0;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_cnt_q       <= {DS_CNT_W{1'b0}};
         busy_cnt_q     <= {LAT_CNT_W{1'b0}};
         s_matrix_q     <= {K{1'b0}};
         start_q        <= 1'b0;
         sample_q       <= {WIDTH_COEFFICIENT{1'b0}};
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         ds_cnt_q       <= ds_cnt_d;
         busy_cnt_q     <= busy_cnt_d;
         s_matrix_q     <= s_matrix_d;
         start_q        <= start_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
      end
   end

`ifdef MCA_OVERRUN_CNT_EN
   ovr_cnt_t ovr_cnt_d, ovr_cnt_q;

   // Saturating count of dropped points; only reset clears it.
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_d && (ovr_cnt_q != OVR_CNT_MAX)) begin
         ovr_cnt_d = ovr_cnt_q + 16'd1;
      end else begin
         ovr_cnt_d = ovr_cnt_q;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovr_cnt_q <= 16'h0000;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`else
   assign overrun_cnt = 16'h0000;
`endif

   assign S_matrix     = s_matrix_q;
   assign start        = start_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_mca_stream_ctrl.sv
// Scoreboard bench for mca_stream_ctrl (N=8, K=32, DS=4, MCA_LATENCY=5).
// The driver pushes expected start/sample/overrun events; a negedge monitor pops and compares.
module tb_mca_stream_ctrl;

   localparam int N     = 8;
   localparam int K     = 32;
   localparam int DS    = 4;
   localparam int L     = 5;
   localparam int W     = 32;
   localparam int DEPTH = K / N;

   logic          clk = 1'b0;
   logic          resetn;
   logic [N-1:0]  ctrl_in;
   logic          ctrl_valid;
   logic [K-1:0]  S_matrix;
   logic          start;
   logic [W-1:0]  mca_sample;
   logic [W-1:0]  sample;
   logic          sample_valid;
   logic          overrun;
   logic [15:0]   overrun_cnt;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mca_stream_ctrl #(
      .N(N), .K(K), .DOWNSAMPLE_RATE(DS), .MCA_LATENCY(L), .WIDTH_COEFFICIENT(W)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .ctrl_in      (ctrl_in),
      .ctrl_valid   (ctrl_valid),
      .S_matrix     (S_matrix),
      .start        (start),
      .mca_sample   (mca_sample),
      .sample       (sample),
      .sample_valid (sample_valid),
      .overrun      (overrun),
      .overrun_cnt  (overrun_cnt)
   );

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } ev_t;

   ev_t sq[$];
   ev_t vq[$];
   ev_t oq[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: counts accepts and tracks when the MCA is free again.
   int           acc          = 0;
   int           drops        = 0;
   int           last_issue_p = -1000;
   logic [K-1:0] hist_m       = '0;
   logic [K-1:0] cur_smat     = '0;

   int           first_start_cyc = -1;
   int           first_valid_cyc = -1;
   logic [K-1:0] first_smat      = '0;
   logic [W-1:0] first_sample    = '0;
   int           coincide        = 0;
   logic         exp_s, exp_v, exp_o;

   function automatic logic [W-1:0] mca_val(input int c);
      if (c < 80) return 32'hFFFF_FFF9;
      else return 32'(c * 37 - 500);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Called when an accept is driven in cycle p.
   task automatic model_accept(input int p, input logic [N-1:0] d);
      hist_m = {hist_m[K-N-1:0], d};
      acc++;
      if (acc >= DEPTH && ((acc - DEPTH + 1) % DS) == 0) begin
         if (p >= last_issue_p + L) begin
            sq.push_back('{p + 1, hist_m});
            vq.push_back('{p + L + 1, mca_val(p + L)});
            last_issue_p = p;
         end else begin
            drops++;
`ifdef MCA_OVERRUN_CNT_EN
            oq.push_back('{p + 1, 32'(drops)});
`else
            oq.push_back('{p + 1, 32'h0});
`endif
         end
      end
   endtask

   task automatic step(input logic v, input logic [N-1:0] d);
      ctrl_valid = v;
      ctrl_in    = d;
      mca_sample = mca_val(cyc);
      if (v && resetn) model_accept(cyc, d);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle, each output pulse must match the head of its queue.
   always @(negedge clk) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
      while (vq.size() > 0 && vq[0].cyc < cyc) void'(vq.pop_front());
      while (oq.size() > 0 && oq[0].cyc < cyc) void'(oq.pop_front());

      exp_s = (sq.size() > 0 && sq[0].cyc == cyc);
      chk("start", 32'(start), 32'(exp_s));
      if (exp_s) begin
         cur_smat = sq[0].val;
         void'(sq.pop_front());
      end
      if (start && first_start_cyc < 0) begin
         first_start_cyc = cyc;
         first_smat      = S_matrix;
      end
      chk("S_matrix", S_matrix, cur_smat);

      exp_v = (vq.size() > 0 && vq[0].cyc == cyc);
      chk("sample_valid", 32'(sample_valid), 32'(exp_v));
      if (exp_v) begin
         chk("sample", sample, vq[0].val);
         void'(vq.pop_front());
      end
      if (sample_valid && first_valid_cyc < 0) begin
         first_valid_cyc = cyc;
         first_sample    = sample;
      end
      if (start && sample_valid) coincide++;

      exp_o = (oq.size() > 0 && oq[0].cyc == cyc);
      chk("overrun", 32'(overrun), 32'(exp_o));
      if (exp_o) begin
         chk("overrun_cnt", 32'(overrun_cnt), oq[0].val);
         void'(oq.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   logic [4:0]  bpat;
   logic [19:0] gpat;
   int          a0;
   int          ph4;
   logic        found;

   initial begin
      resetn     = 1'b1;
      ctrl_valid = 1'b0;
      ctrl_in    = '0;
      mca_sample = '0;
      #1 resetn  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_S_matrix", S_matrix, 32'h0);
      chk("rst_start", 32'(start), 32'h0);
      chk("rst_sample", sample, 32'h0);
      chk("rst_sample_valid", 32'(sample_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_overrun_cnt", 32'(overrun_cnt), 32'h0);

      resetn = 1'b1;
      a0     = cyc;

      // Fill, latency and overrun: continuous accepts, ctrl_in = sample index.
      for (int i = 0; i < 24; i++) step(1'b1, 8'(i));

      // Boundary: 4 accepts per 5 cycles puts every point on busy_cnt==1.
      bpat = 5'b10111;
      for (int i = 0; i < 30; i++) step(bpat[3'(i % 5)], 8'(8'h40 + i));

      // Gaps: fixed 30% duty valid pattern.
      gpat = 20'b01001000101001000100;
      for (int i = 0; i < 100; i++) step(gpat[5'(i % 20)], 8'(i * 7 + 3));

      // Reset mid-busy: run until an issue, then reset two cycles into the busy window.
      ph4   = cyc;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (last_issue_p >= ph4 && cyc == last_issue_p + 3) found = 1'b1;
         else step(1'b1, 8'(8'hA0 + i));
      end
      chk("reset_window_found", 32'(found), 32'h1);

      ctrl_valid = 1'b0;
      #2 resetn  = 1'b0;
      #1;
      chk("async_rst_S_matrix", S_matrix, 32'h0);
      chk("async_rst_start", 32'(start), 32'h0);
      chk("async_rst_sample", sample, 32'h0);
      chk("async_rst_sample_valid", 32'(sample_valid), 32'h0);
      chk("async_rst_overrun", 32'(overrun), 32'h0);
      chk("async_rst_overrun_cnt", 32'(overrun_cnt), 32'h0);
      sq.delete();
      vq.delete();
      oq.delete();
      acc          = 0;
      drops        = 0;
      hist_m       = '0;
      cur_smat     = '0;
      last_issue_p = -1000;
      repeat (3) step(1'b0, 8'h00);
      resetn = 1'b1;

      // Partial refill must not start; a full refill must.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i));
      repeat (15) step(1'b0, 8'h00);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hD0 + i));
      repeat (20) step(1'b0, 8'h00);

      chk("queues_drained", 32'(sq.size() + vq.size() + oq.size()), 32'h0);
      chk("first_S_matrix", first_smat, 32'h0304_0506);
      chk("first_start_delay", 32'(first_start_cyc - a0), 32'd7);
      chk("start_to_valid", 32'(first_valid_cyc - first_start_cyc), 32'(L));
      chk("first_sample", first_sample, 32'hFFFF_FFF9);
      chk("boundary_coincide", 32'(coincide > 0), 32'h1);
`ifdef MCA_OVERRUN_CNT_EN
      chk("final_overrun_cnt", 32'(overrun_cnt), 32'd1);
`else
      chk("final_overrun_cnt", 32'(overrun_cnt), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
